// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle RV32I/RV32E core with internal register file and one
//   shared req/ack memory port for instruction fetch and data access.
// Latency: 4 cycles per ALU/branch/jump instruction, 5 per load/store with
//   zero-wait memory; every memory wait cycle adds one.
// Backpressure: mem_req is held with stable address/data/strobes until
//   mem_ack; the core simply stalls in FETCH or MEM while the memory waits.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   mem_req/mem_we        request valid / write (1) or read (0)
//   mem_addr              byte address (word-aligned for fetches)
//   mem_wdata/mem_wstrb   lane-replicated store data / byte enables (0 on reads)
//   mem_ack/mem_rdata     request completed this cycle / read data
//   halted/illegal        core stopped / stop caused by an illegal or
//                         misaligned instruction (ECALL/EBREAK leave it 0)
//   perf_cycles/instret   performance counters, only present when the macro
//                         CPU_MC_PERF_CNT_EN is defined; tied to zero otherwise
//
// Parameters: RESET_PC (reset vector), REG_COUNT (32 = RV32I, 16 = RV32E).

module cpu_mc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  // Register index width actually needed for the configured register file.
  localparam int         RW      = (REG_COUNT > 16) ? 5 : 4;
  localparam logic [5:0] REG_LIM = 6'(REG_COUNT);

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] imm_q;
  logic [31:0] result_q;
  logic [31:0] next_pc_q;
  logic [31:0] regs [REG_COUNT];

  // Instruction fields; ir is stable from DECODE through WB.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd_f   = ir[11:7];
  assign rs1_f  = ir[19:15];
  assign rs2_f  = ir[24:20];

  // ---------------------------------------------------------------- decode
  logic        dec_legal;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        uses_rd;
  logic        idx_bad;
  logic        dec_ok;
  logic [31:0] dec_imm;
  logic        is_load;
  logic        is_store;
  logic        is_mem;

  always_comb begin
    dec_legal = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    uses_rd   = 1'b0;
    dec_imm   = {{20{ir[31]}}, ir[31:20]};
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_legal = 1'b1;
        uses_rd   = 1'b1;
        dec_imm   = {ir[31:12], 12'h000};
      end
      OPC_JAL: begin
        dec_legal = 1'b1;
        uses_rd   = 1'b1;
        dec_imm   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec_legal = (funct3 == 3'b000);
        uses_rd   = 1'b1;
        uses_rs1  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec_imm   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OPC_LOAD: begin
        dec_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        uses_rd   = 1'b1;
        uses_rs1  = 1'b1;
      end
      OPC_STORE: begin
        dec_legal = !funct3[2] && (funct3[1:0] != 2'b11);
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        dec_imm   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OPC_OPIMM: begin
        // Only the shift-immediate forms constrain the upper immediate bits.
        case (funct3)
          3'b001:  dec_legal = (funct7 == 7'h00);
          3'b101:  dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: dec_legal = 1'b1;
        endcase
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        dec_legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_FENCE:  dec_legal = (funct3 == 3'b000);
      OPC_SYSTEM: dec_legal = (ir == INSN_ECALL) || (ir == INSN_EBREAK);
      default:    dec_legal = 1'b0;
    endcase
  end

  // Register indices are only range-checked for fields the format really
  // uses, so U/J immediates that overlap rs1/rs2 never trip RV32E.
  assign idx_bad  = (uses_rd  && ({1'b0, rd_f}  >= REG_LIM)) ||
                    (uses_rs1 && ({1'b0, rs1_f} >= REG_LIM)) ||
                    (uses_rs2 && ({1'b0, rs2_f} >= REG_LIM));
  assign dec_ok   = dec_legal && !idx_bad;
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);
  assign is_mem   = is_load || is_store;

  // --------------------------------------------------------------- execute
  logic [31:0] alu_b;
  logic        alu_alt;
  logic [4:0]  shamt;
  logic [31:0] alu_res;
  logic        br_take;
  logic [31:0] base_sum;
  logic [31:0] pc_plus4;
  logic [31:0] pc_rel;
  logic [31:0] ex_result;
  logic [31:0] ex_next_pc;
  logic        ex_redirect;
  logic        ls_misalign;
  logic        target_misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_q : imm_q;
    // ir[30] selects SUB only for register ops; for ADDI it is an imm bit.
    alu_alt = ir[30] && ((opcode == OPC_OP) || (funct3 == 3'b101));
    shamt   = alu_b[4:0];
    case (funct3)
      3'b000:  alu_res = alu_alt ? (rs1_q - alu_b) : (rs1_q + alu_b);
      3'b001:  alu_res = rs1_q << shamt;
      3'b010:  alu_res = {31'b0, ($signed(rs1_q) < $signed(alu_b))};
      3'b011:  alu_res = {31'b0, (rs1_q < alu_b)};
      3'b100:  alu_res = rs1_q ^ alu_b;
      3'b101:  alu_res = alu_alt ? $unsigned($signed(rs1_q) >>> shamt) : (rs1_q >> shamt);
      3'b110:  alu_res = rs1_q | alu_b;
      default: alu_res = rs1_q & alu_b;
    endcase

    case (funct3)
      3'b000:  br_take = (rs1_q == rs2_q);
      3'b001:  br_take = (rs1_q != rs2_q);
      3'b100:  br_take = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  br_take = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  br_take = (rs1_q < rs2_q);
      3'b111:  br_take = (rs1_q >= rs2_q);
      default: br_take = 1'b0;
    endcase

    base_sum = rs1_q + imm_q;
    pc_plus4 = pc + 32'd4;
    pc_rel   = pc + imm_q;

    ex_result   = alu_res;
    ex_next_pc  = pc_plus4;
    ex_redirect = 1'b0;
    case (opcode)
      OPC_LUI:   ex_result = imm_q;
      OPC_AUIPC: ex_result = pc_rel;
      OPC_JAL: begin
        ex_result   = pc_plus4;
        ex_next_pc  = pc_rel;
        ex_redirect = 1'b1;
      end
      OPC_JALR: begin
        ex_result   = pc_plus4;
        ex_next_pc  = base_sum & 32'hFFFF_FFFE;
        ex_redirect = 1'b1;
      end
      OPC_BRANCH: begin
        if (br_take) begin
          ex_next_pc  = pc_rel;
          ex_redirect = 1'b1;
        end
      end
      default: ;
    endcase

    // A not-taken branch never faults on its (unused) target.
    target_misalign = ex_redirect && ex_next_pc[1];
    ls_misalign     = ((funct3[1:0] == 2'b10) && (base_sum[1:0] != 2'b00)) ||
                      ((funct3[1:0] == 2'b01) && base_sum[0]);

    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{rs2_q[7:0]}};
        st_wstrb = 4'b0001 << base_sum[1:0];
      end
      2'b01: begin
        st_wdata = {2{rs2_q[15:0]}};
        st_wstrb = 4'b0011 << base_sum[1:0];
      end
      default: begin
        st_wdata = rs2_q;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // ------------------------------------------------------- load extraction
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  always_comb begin
    case (mem_addr[1:0])
      2'b00:   lane_byte = mem_rdata[7:0];
      2'b01:   lane_byte = mem_rdata[15:8];
      2'b10:   lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_val = {24'b0, lane_byte};
      3'b101:  load_val = {16'b0, lane_half};
      default: load_val = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------- control FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      next_pc_q <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          // First cycle after reset arrives here with mem_req low; raise it
          // before any ack can be accepted so a stale ack is ignored.
          if (!mem_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_addr  <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!dec_ok) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            rs1_q <= regs[rs1_f[RW-1:0]];
            rs2_q <= regs[rs2_f[RW-1:0]];
            imm_q <= dec_imm;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (opcode == OPC_SYSTEM) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if ((is_mem && ls_misalign) || target_misalign) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= base_sum;
            mem_wdata <= is_store ? st_wdata : 32'h0;
            mem_wstrb <= is_store ? st_wstrb : 4'b0000;
            next_pc_q <= pc_plus4;
            state     <= S_MEM;
          end else begin
            result_q  <= ex_result;
            next_pc_q <= ex_next_pc;
            state     <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (!mem_we) begin
              result_q <= load_val;
            end
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            state     <= S_WB;
          end
        end
        S_WB: begin
          // Issue the next fetch directly so the following FETCH cycle can
          // complete on a same-cycle ack.
          pc        <= next_pc_q;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_wstrb <= 4'b0000;
          mem_addr  <= next_pc_q;
          state     <= S_FETCH;
        end
        S_HALT: begin
          mem_req <= 1'b0;
        end
        default: begin
          state   <= S_HALT;
          mem_req <= 1'b0;
          halted  <= 1'b1;
          illegal <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------- register file
  // Entry 0 is never written, so x0 reads as zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if ((state == S_WB) && uses_rd && (rd_f != 5'd0)) begin
      regs[rd_f[RW-1:0]] <= result_q;
    end
  end

  // ------------------------------------------------------- perf counters
`ifdef CPU_MC_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (!halted) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
      if (state == S_WB) begin
        ret_cnt <= ret_cnt + 32'd1;
      end
    end
  end

  assign perf_cycles  = cyc_cnt;
  assign perf_instret = ret_cnt;
`else
  assign perf_cycles  = 32'h0;
  assign perf_instret = 32'h0;
`endif

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Multi-cycle RV32I core, successor to the single-cycle cpu.
- Instruction and data traffic share one external memory port with a req/ack handshake, so memories with variable latency are supported.
- The register file is internal.
- Sits between the top level and a unified instr/data memory.
- Adds over the single-cycle core: configurable reset vector, configurable register count (RV32I/RV32E), branches/jumps, byte-lane stores, wait states, halt on illegal/ECALL/EBREAK.

Parameters:
- RESET_PC, 32'h0000_0000, pc value loaded on reset.
- REG_COUNT, 32, number of architectural registers; legal values 32 (RV32I) or 16 (RV32E).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  32  byte address; word-aligned for fetches.
- mem_wdata  output  32  store data, already lane-shifted.
- mem_wstrb  output  4  byte enables for writes; 4'b0000 for reads.
- mem_ack  input  1  request completed this cycle.
- mem_rdata  input  32  read data, valid while mem_ack=1.
- halted  output  1  core stopped.
- illegal  output  1  halt cause was an illegal or misaligned instruction.
- perf_cycles  output  32  cycle counter (see Optional Feature).
- perf_instret  output  32  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_PC, all registers=0, state=FETCH.
  - mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - halted=0, illegal=0, perf counters=0.
  - Reset during an outstanding request drops mem_req immediately; the transaction is abandoned and a stale mem_ack after release is ignored unless the core is in FETCH/MEM with mem_req=1.
- States: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH, plus HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Stays until mem_ack=1; instruction is latched on that edge and the state moves to DECODE.
  - mem_ack with mem_req=0 is ignored.
- DECODE: read rs1/rs2, form the immediate (I/S/B/U/J, sign-extended), classify opcode. Illegal encoding -> HALT with illegal=1. Illegal cases:
  - unknown opcode/funct3/funct7;
  - rs1/rs2/rd index >= REG_COUNT.
- EXEC:
  - ALU ops: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, immediate forms included. Shift amount = low 5 bits.
  - Branches compare rs1/rs2; target = pc+immB.
  - JAL target = pc+immJ; JALR target = (rs1+immI) & ~1.
  - LUI result = immU; AUIPC result = pc+immU.
  - Load/store address = rs1+imm. Misaligned access -> HALT, illegal=1:
    - word with addr[1:0]!=0;
    - half with addr[0]=1.
  - Jump/branch target with bit1=1 -> HALT, illegal=1.
  - ECALL/EBREAK -> HALT, illegal=0.
  - FENCE executes as a NOP.
- MEM (loads/stores only):
  - mem_req=1 until mem_ack.
  - Store: mem_we=1, mem_wdata = rs2 replicated per lane, mem_wstrb = SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
  - Load: mem_addr = full address, mem_wstrb=0. On ack, extract the byte/half at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
  - mem_addr/mem_we/mem_wdata/mem_wstrb stay stable while mem_req=1 and mem_ack=0.
- WB:
  - Write rd unless rd=0 (x0 always reads 0).
  - pc = target if a branch is taken or on a jump, else pc+4; pc wraps modulo 2^32.
  - JAL/JALR write pc+4.
- Latency with zero wait states (ack in the same cycle as req):
  - ALU/branch/jump: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle adds 1.
- HALT: terminal until reset; mem_req=0, halted=1, pc frozen at the faulting instruction.

Optional Feature:
- Macro CPU_MC_PERF_CNT_EN.
- Defined:
  - perf_cycles increments every cycle while not halted.
  - perf_instret increments on every WB.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to 32'h0 and no counter flops exist.

Test Plan:
- Zero-wait memory holding ADDI x1,x0,5; ADDI x2,x1,-7; SUB x3,x1,x2 -> x3=7, x2=32'hFFFFFFFE; each instruction takes 4 cycles.
- SB x1 to 0x103 with x1=0x12345678 -> mem_wstrb=1000, mem_wdata[31:24]=0x78. LB from the same byte reading 0x80 -> rd=32'hFFFFFF80; LBU -> 32'h00000080.
- Memory acks after 3 wait cycles -> mem_req and mem_addr held for 4 cycles; fetch completes correctly.
- BEQ x0,x0,-8 at pc 0x10 -> next fetch addr 0x08. JALR x1,x5,1 with x5=0x20 -> pc=0x20, x1=pc+4.
- Opcode 0x7F, and separately LW at 0x102 -> halted=1, illegal=1, no further mem_req. ECALL -> halted=1, illegal=0.
- REG_COUNT=16: ADDI x20,x0,1 -> illegal halt. Reset asserted mid-FETCH wait -> mem_req=0 immediately; after release, fetch resumes from RESET_PC.
